// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch unit: owns the PC, fetches over req/ack, feeds IF/ID.
// Optional misaligned-jump detection and target word-alignment under IFU_MISALIGN_CHK_EN.
`ifndef HOLD_FLAG_BUS
`define HOLD_FLAG_BUS 2:0
`endif
`ifndef HOLD_EN
`define HOLD_EN 3'b001
`endif
`ifndef INST_NOP
`define INST_NOP 32'h0000_0001
`endif

module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  jumpFlagIn,
  input  logic [31:0]           jumpAddrIn,
  input  logic [`HOLD_FLAG_BUS] holdFlagIn,
  output logic                  memReqOut,
  output logic [31:0]           memAddrOut,
  input  logic                  memAckIn,
  input  logic [31:0]           memDataIn,
  output logic [31:0]           instOut,
  output logic [31:0]           instAddrOut,
  output logic                  instValidOut,
  output logic                  misalignOut
);

  typedef enum logic [1:0] {IDLE, FETCH, HELD, FLUSH} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_inst_q, buf_inst_d;
  logic [31:0] buf_addr_q, buf_addr_d;
  logic [31:0] flush_addr_q, flush_addr_d;
  logic        hold;
  logic [31:0] jump_tgt;

  assign hold = (holdFlagIn >= `HOLD_EN);

`ifdef IFU_MISALIGN_CHK_EN
  assign jump_tgt    = {jumpAddrIn[31:2], 2'b00};
  assign misalignOut = ~rst & jumpFlagIn & (|jumpAddrIn[1:0]);
`else
  assign jump_tgt    = jumpAddrIn;
  assign misalignOut = 1'b0;
`endif

  // A stale request keeps its original address on the bus until its ack arrives.
  assign memReqOut  = (state_q == FETCH) || (state_q == FLUSH);
  assign memAddrOut = (state_q == FLUSH) ? flush_addr_q : pc_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    buf_inst_d   = buf_inst_q;
    buf_addr_d   = buf_addr_q;
    flush_addr_d = flush_addr_q;
    instOut      = `INST_NOP;
    instAddrOut  = 32'h0;
    instValidOut = 1'b0;
    case (state_q)
      IDLE: begin
        if (jumpFlagIn) pc_d = jump_tgt;
        state_d = FETCH;
      end
      FETCH: begin
        if (jumpFlagIn) begin
          pc_d         = jump_tgt;
          flush_addr_d = pc_q;
          state_d      = memAckIn ? FETCH : FLUSH;
        end else if (hold) begin
          if (memAckIn) begin
            buf_inst_d = memDataIn;
            buf_addr_d = pc_q;
            pc_d       = pc_q + 32'd4;
            state_d    = HELD;
          end
        end else if (memAckIn) begin
          instOut      = memDataIn;
          instAddrOut  = pc_q;
          instValidOut = 1'b1;
          pc_d         = pc_q + 32'd4;
        end
      end
      HELD: begin
        if (jumpFlagIn) begin
          pc_d    = jump_tgt;
          state_d = FETCH;
        end else if (!hold) begin
          instOut      = buf_inst_q;
          instAddrOut  = buf_addr_q;
          instValidOut = 1'b1;
          state_d      = FETCH;
        end
      end
      FLUSH: begin
        if (jumpFlagIn) pc_d = jump_tgt;
        if (memAckIn) state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      buf_inst_q   <= 32'h0;
      buf_addr_q   <= 32'h0;
      flush_addr_q <= RESET_PC;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      buf_inst_q   <= buf_inst_d;
      buf_addr_q   <= buf_addr_d;
      flush_addr_q <= flush_addr_d;
    end
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch unit that owns the program counter. It issues word reads to instruction memory over a req/ack handshake and presents each fetched instruction and its address to the IF/ID pipeline register. It honours pipeline hold requests and jump redirects, and squashes responses that become stale. It sits between instruction memory and the IF/ID register, as the producer of that register's `instIn`/`instAddrIn`.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `jumpFlagIn`  in  1  redirect request from execute.
- `jumpAddrIn`  in  32  redirect target.
- `holdFlagIn`  in  `HOLD_FLAG_BUS`  pipeline hold level; fetch stalls when `holdFlagIn >= `HOLD_EN`.
- `memReqOut`  out  1  read request to instruction memory.
- `memAddrOut`  out  32  read address.
- `memAckIn`  in  1  response valid; completes the outstanding request.
- `memDataIn`  in  32  instruction word, valid with `memAckIn`.
- `instOut`  out  32  instruction to IF/ID; `INST_NOP` when not valid.
- `instAddrOut`  out  32  address of `instOut`; 0 when not valid.
- `instValidOut`  out  1  `instOut`/`instAddrOut` carry a real instruction this cycle.
- `misalignOut`  out  1  one-cycle pulse on a misaligned jump target (see Configuration).

## Operation
- Registers: `pc` (32), `state`, `bufInst` (32), `bufAddr` (32).
- States:
  - IDLE: `memReqOut`=0; go to FETCH next cycle.
  - FETCH: `memReqOut`=1, `memAddrOut`=`pc`.
  - HELD: a completed word sits in the buffer, waiting for hold release.
  - FLUSH: waiting to discard a stale response.
- Bus rule: once `memReqOut` is asserted, `memReqOut` and `memAddrOut` stay constant until the cycle `memAckIn`=1. An outstanding request is never withdrawn.
- FETCH, ack, no hold, no jump:
  - `instOut`=`memDataIn`, `instAddrOut`=`pc`, `instValidOut`=1, all combinational.
  - `pc`<=`pc`+4; stay in FETCH. Back-to-back fetches run at 1 instruction/cycle with a zero-wait memory.
- FETCH, ack, hold: `bufInst`<=`memDataIn`, `bufAddr`<=`pc`, `pc`<=`pc`+4, go to HELD. Outputs this cycle are NOP/0/valid 0.
- FETCH, no ack, hold: request stays asserted and unchanged.
- HELD:
  - `memReqOut`=0.
  - When hold drops: drive `bufInst`/`bufAddr` with `instValidOut`=1 for that cycle, then go to FETCH.
- Jump in FETCH with ack: the ack is discarded (outputs NOP), `pc`<=target, stay in FETCH.
- Jump in FETCH without ack: `pc`<=target, go to FLUSH.
- Jump in HELD: buffer discarded, `pc`<=target, go to FETCH.
- Jump in IDLE: `pc`<=target.
- FLUSH:
  - Old request is held until `memAckIn`; the response is discarded and outputs stay NOP.
  - Then go to FETCH at the new `pc`.
  - A further jump in FLUSH updates `pc` only (latest jump wins).
- Priority: `rst` > jump > hold > ack.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 0.

## Timing
- Reset values (async, immediate):
  - state=IDLE, `pc`=`RESET_PC`.
  - `memReqOut`=0, `memAddrOut`=`RESET_PC`.
  - `instOut`=`INST_NOP`, `instAddrOut`=0, `instValidOut`=0, `misalignOut`=0.
- First request is asserted in the second cycle after `rst` deasserts.
- Latency from request to `instOut` equals memory wait states: 0 extra cycles; outputs are combinational from `memAckIn`/`memDataIn`.
- Jump to first request at target: next cycle (FETCH/IDLE/HELD), or the cycle after the stale ack (FLUSH).
- Hold release to buffered instruction output: same cycle the hold drops.
- Reset mid-request abandons the request; memory must tolerate `memReqOut` dropping on reset.

## Configuration
- `IFU_MISALIGN_CHK_EN` defined:
  - A jump with `jumpAddrIn[1:0]`!=0 pulses `misalignOut`=1 for that cycle.
  - `pc` loads `{jumpAddrIn[31:2],2'b00}`.
- Not defined:
  - `misalignOut` is tied 0.
  - `pc` loads `jumpAddrIn` unmodified.

## Test plan
- Zero-wait memory returning `32'h0000_0013` at every address, reset release -> `memAddrOut` 0,4,8,… on consecutive cycles; `instAddrOut` matches and `instValidOut`=1 each cycle.
- Memory with 2 wait states -> `memReqOut`/`memAddrOut` stable for 3 cycles per word; one valid output every 3 cycles.
- Hold asserted on an ack cycle at pc=8 for 4 cycles -> no valid output and `memReqOut`=0 during the hold; on release, `instAddrOut`=8 valid; next request at 12.
- Jump to 32'h100 while request at 32'h20 is pending with 3 wait states -> 32'h20 held until ack, response dropped (`instValidOut`=0), next request at 32'h100.
- Jump to 32'h102 with `IFU_MISALIGN_CHK_EN` -> `misalignOut` pulses once, next `memAddrOut`=32'h100. Without the macro -> `misalignOut`=0, `memAddrOut`=32'h102.
- `rst` asserted mid-HELD -> all outputs return to reset values immediately; fetch restarts at `RESET_PC`.
